pipe_register: RTL

Parametrised, elastic pipeline register: a chain of DEPTH full-throughput skid-buffer stages carrying WIDTH-bit words under a valid/ready handshake, with synchronous flush and an occupancy count. It is the general-purpose pipeline register for the datapath. It slots between any producer and consumer that need registered timing on both data and backpressure, and it sustains one word per cycle.

---
 rtl/pipe_register.sv | 117 +++++++++++
 1 files changed

// File: rtl/pipe_register.sv
// Elastic pipeline register: DEPTH skid stages, one word/cycle, registered ready path.
// Latency DEPTH cycles; in_ready depends only on stage-0 skid state, never on out_ready.
module pipe_register #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int LW = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LW-1:0]    level
);

  logic [DEPTH-1:0] main_v_q, main_v_d;
  logic [DEPTH-1:0] skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_d_q [DEPTH];
  logic [WIDTH-1:0] main_d_d [DEPTH];
  logic [WIDTH-1:0] skid_d_q [DEPTH];
  logic [WIDTH-1:0] skid_d_d [DEPTH];

  logic [DEPTH-1:0] up_v, up_rdy, dn_rdy, up_fire;
  logic [WIDTH-1:0] up_d [DEPTH];
  logic [LW-1:0]    level_q, level_d;
  logic             in_fire, out_fire;

  // Stage s takes its input from stage s-1 and sees stage s+1's skid as its ready.
  for (genvar s = 0; s < DEPTH; s++) begin : g_link
    if (s == 0) begin : g_head
      assign up_v[s]   = in_valid;
      assign up_d[s]   = in_data;
      assign up_rdy[s] = !skid_v_q[s] && !rst && !flush;
    end else begin : g_body
      assign up_v[s]   = main_v_q[s-1];
      assign up_d[s]   = main_d_q[s-1];
      assign up_rdy[s] = !skid_v_q[s];
    end
    if (s == DEPTH-1) begin : g_tail
      assign dn_rdy[s] = out_ready;
    end else begin : g_mid
      assign dn_rdy[s] = !skid_v_q[s+1];
    end
  end

  assign up_fire = up_v & up_rdy;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d_d = main_d_q;
    skid_d_d = skid_d_q;
    for (int s = 0; s < DEPTH; s++) begin
      if (!main_v_q[s] || dn_rdy[s]) begin
        if (skid_v_q[s]) begin
          main_v_d[s] = 1'b1;
          main_d_d[s] = skid_d_q[s];
          skid_v_d[s] = 1'b0;
        end else if (up_fire[s]) begin
          main_v_d[s] = 1'b1;
          main_d_d[s] = up_d[s];
        end else begin
          main_v_d[s] = 1'b0;
        end
      end else if (up_fire[s]) begin
        skid_v_d[s] = 1'b1;
        skid_d_d[s] = up_d[s];
      end
    end
  end

  assign in_fire  = up_fire[0];
  assign out_fire = main_v_q[DEPTH-1] && out_ready;

  always_comb begin
    level_d = level_q;
    if (in_fire && !out_fire) begin
      level_d = level_q + LW'(1);
    end else if (!in_fire && out_fire) begin
      level_d = level_q - LW'(1);
    end
  end

  // Flush drops the valids but leaves the data registers untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q <= '0;
      skid_v_q <= '0;
      level_q  <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        main_d_q[s] <= RESET_VALUE;
        skid_d_q[s] <= RESET_VALUE;
      end
    end else if (flush) begin
      main_v_q <= '0;
      skid_v_q <= '0;
      level_q  <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_d_q <= main_d_d;
      skid_d_q <= skid_d_d;
      level_q  <= level_d;
    end
  end

  assign in_ready  = up_rdy[0];
  assign out_valid = main_v_q[DEPTH-1];
  assign out_data  = main_d_q[DEPTH-1];
  assign level     = level_q;

endmodule
